// File: rtl/dac_spi_pkg.sv
`default_nettype none
// ---- dac_spi_pkg : frame geometry, state encoding, data-word formatting  (rev 1.0) ----
// Build option DAC_SPI_OFFSET_BINARY_EN: invert data MSB (two's complement -> offset binary).
package dac_spi_pkg;
  localparam int FRAME_W  = 24;
  localparam int DATA_W   = 16;
  localparam int CMD_W    = 8;
  localparam int HALF_CNT = 2 * FRAME_W;

  localparam logic [CMD_W-1:0] DEF_CMD_A = 8'h10;
  localparam logic [CMD_W-1:0] DEF_CMD_B = 8'h24;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_START = S_START,
    ST_SHIFT = S_SHIFT,
    ST_STOP  = S_STOP,
    ST_GAP   = S_GAP
  } state_t;

  // Command bytes never pass through here, only the 16-bit sample words.
  function automatic logic [DATA_W-1:0] fmt_data(input logic [DATA_W-1:0] d);
`ifdef DAC_SPI_OFFSET_BINARY_EN
    return {~d[DATA_W-1], d[DATA_W-2:0]};
`else
    return d;
`endif
  endfunction
endpackage
`default_nettype wire

// File: rtl/dac_spi_writer_sclk_tick_gen.sv
`default_nettype none
// ---- sclk_tick_gen : CLK_DIV down-counter, one tick per SCLK half-period  (rev 1.0) ----
module sclk_tick_gen
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic inst_arst_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);
  localparam int            CW     = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == '0);

  // restart aligns the first tick of every state to CLK_DIV cycles after entry
  always_ff @(posedge i_clk or negedge inst_arst_n) begin
    if (!inst_arst_n)         cnt <= RELOAD;
    else if (restart || tick) cnt <= RELOAD;
    else if (enable)          cnt <= cnt - CW'(1);
  end
endmodule
`default_nettype wire

// File: rtl/dac_spi_writer.sv
`default_nettype none
// ---- dac_spi_writer : cos/sin pair -> two 24-bit SPI frames to a dual 16-bit DAC  (rev 1.0) ----
// Build option DAC_SPI_OFFSET_BINARY_EN sends data words in offset binary.
module dac_spi_writer
  import dac_spi_pkg::*;
#(
  parameter int               CLK_DIV = 2,
  parameter int               CS_GAP  = 4,
  parameter logic [CMD_W-1:0] CMD_A   = DEF_CMD_A,
  parameter logic [CMD_W-1:0] CMD_B   = DEF_CMD_B
) (
  input  logic              i_clk,
  input  logic              inst_arst_n,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_cos,
  input  logic [DATA_W-1:0] i_sin,
  input  logic              i_clr_overrun,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_cs_n,
  output logic              o_busy,
  output logic              o_pair_done,
  output logic              o_overrun
);
  localparam int            GW         = $clog2(CS_GAP + 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(CS_GAP - 1);
  localparam logic [5:0]    LAST_HALF  = 6'(HALF_CNT - 1);

  state_t              state, state_nx;
  logic [2*DATA_W-1:0] pend;
  logic                pend_full, capture, take;
  logic                tick, tick_en, restart;
  logic [FRAME_W-1:0]  shreg, shreg_nx;
  logic [DATA_W-1:0]   sin_hold, sin_hold_nx;
  logic                chan_b, chan_b_nx;
  logic [5:0]          bit_cnt, bit_cnt_nx;
  logic [GW-1:0]       gap_cnt, gap_cnt_nx;
  logic                sclk_nx, mosi_nx, cs_n_nx, done_nx;

  assign capture = i_valid && i_enable;
  assign take    = (state == ST_IDLE) && pend_full;
  assign o_busy  = (state != ST_IDLE);
  assign tick_en = (state == ST_START) || (state == ST_SHIFT) || (state == ST_STOP);
  assign restart = (state_nx != state);

  // A capture coinciding with a take refills the buffer the FSM just emptied: not an overrun.
  always_ff @(posedge i_clk or negedge inst_arst_n) begin
    if (!inst_arst_n) begin
      pend      <= '0;
      pend_full <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (capture)   pend <= {i_cos, i_sin};
      if (capture)   pend_full <= 1'b1;
      else if (take) pend_full <= 1'b0;
      if (capture && pend_full && !take) o_overrun <= 1'b1;
      else if (i_clr_overrun)            o_overrun <= 1'b0;
    end
  end

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk       (i_clk),
    .inst_arst_n (inst_arst_n),
    .enable      (tick_en),
    .restart     (restart),
    .tick        (tick)
  );

  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    sin_hold_nx = sin_hold;
    chan_b_nx   = chan_b;
    bit_cnt_nx  = bit_cnt;
    gap_cnt_nx  = gap_cnt;
    sclk_nx     = o_sclk;
    mosi_nx     = o_mosi;
    cs_n_nx     = o_cs_n;
    done_nx     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        mosi_nx = 1'b0;
        if (pend_full) begin
          shreg_nx    = {CMD_A, fmt_data(pend[2*DATA_W-1:DATA_W])};
          sin_hold_nx = pend[DATA_W-1:0];
          chan_b_nx   = 1'b0;
          cs_n_nx     = 1'b0;
          state_nx    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_cnt_nx = '0;
          state_nx   = ST_SHIFT;
        end
      end
      // Even half-periods end with a rising edge (new bit out), odd ones with a falling edge.
      ST_SHIFT: begin
        if (tick) begin
          if (bit_cnt == LAST_HALF) begin
            sclk_nx  = 1'b0;
            state_nx = ST_STOP;
          end else begin
            bit_cnt_nx = bit_cnt + 6'd1;
            sclk_nx    = ~o_sclk;
            if (!bit_cnt[0]) begin
              mosi_nx  = shreg[FRAME_W-1];
              shreg_nx = {shreg[FRAME_W-2:0], 1'b0};
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          cs_n_nx    = 1'b1;
          gap_cnt_nx = GAP_RELOAD;
          state_nx   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_nx = gap_cnt - GW'(1);
        end else if (!chan_b) begin
          shreg_nx  = {CMD_B, fmt_data(sin_hold)};
          chan_b_nx = 1'b1;
          cs_n_nx   = 1'b0;
          state_nx  = ST_START;
        end else begin
          done_nx  = 1'b1;
          mosi_nx  = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge inst_arst_n) begin
    if (!inst_arst_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      sin_hold    <= '0;
      chan_b      <= 1'b0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      o_sclk      <= 1'b0;
      o_mosi      <= 1'b0;
      o_cs_n      <= 1'b1;
      o_pair_done <= 1'b0;
    end else begin
      state       <= state_nx;
      shreg       <= shreg_nx;
      sin_hold    <= sin_hold_nx;
      chan_b      <= chan_b_nx;
      bit_cnt     <= bit_cnt_nx;
      gap_cnt     <= gap_cnt_nx;
      o_sclk      <= sclk_nx;
      o_mosi      <= mosi_nx;
      o_cs_n      <= cs_n_nx;
      o_pair_done <= done_nx;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dac_spi_writer.sv
`default_nettype none
// ---- tb_dac_spi_writer : randomized bench with a transaction-level model of the SPI writer  (rev 1.0) ----
module tb_dac_spi_writer;
  localparam logic [7:0] CMD_A     = 8'h10;
  localparam logic [7:0] CMD_B     = 8'h24;
  localparam longint     FRAME_CYC = 50 * 2 + 4;
`ifdef DAC_SPI_OFFSET_BINARY_EN
  localparam logic [23:0] EXP_A = 24'h100001;
  localparam logic [23:0] EXP_B = 24'h24FFFE;
`else
  localparam logic [23:0] EXP_A = 24'h108001;
  localparam logic [23:0] EXP_B = 24'h247FFE;
`endif

  logic clk, arst_n, en, valid, clr, f_valid;
  logic [15:0] cos, sin, f_cos, f_sin;
  logic sclk, mosi, cs_n, busy, done, ovr;
  logic f_sclk, f_mosi, f_cs_n, f_busy, f_done, f_ovr;

  dac_spi_writer u_dut (
    .i_clk(clk), .inst_arst_n(arst_n), .i_enable(en), .i_valid(valid),
    .i_cos(cos), .i_sin(sin), .i_clr_overrun(clr),
    .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n), .o_busy(busy),
    .o_pair_done(done), .o_overrun(ovr)
  );

  dac_spi_writer #(.CLK_DIV(1), .CS_GAP(1)) u_fast (
    .i_clk(clk), .inst_arst_n(arst_n), .i_enable(en), .i_valid(f_valid),
    .i_cos(f_cos), .i_sin(f_sin), .i_clr_overrun(clr),
    .o_sclk(f_sclk), .o_mosi(f_mosi), .o_cs_n(f_cs_n), .o_busy(f_busy),
    .o_pair_done(f_done), .o_overrun(f_ovr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fmt(input logic [15:0] d);
`ifdef DAC_SPI_OFFSET_BINARY_EN
    return d ^ 16'h8000;
`else
    return d;
`endif
  endfunction

  // Reference model: a pair is taken on the first idle cycle with something pending;
  // the writer is then busy for two whole frames.
  longint      cyc = 0;
  longint      idle_at = 0;
  logic        pend_v = 1'b0, ovr_m = 1'b0, tk, setov;
  logic [15:0] pend_c, pend_s;
  logic [23:0] exp_frames[$];
  longint      exp_fall[$];
  longint      exp_done[$];
  logic [23:0] f_exp[$];

  initial forever begin
    @(posedge clk);
    if (!arst_n) begin
      pend_v = 1'b0; ovr_m = 1'b0; idle_at = 0;
      exp_frames.delete(); exp_fall.delete(); exp_done.delete();
    end else begin
      tk = pend_v && (cyc >= idle_at);
      if (tk) begin
        exp_frames.push_back({CMD_A, fmt(pend_c)});
        exp_frames.push_back({CMD_B, fmt(pend_s)});
        exp_fall.push_back(cyc + 1);
        exp_fall.push_back(cyc + 1 + FRAME_CYC);
        exp_done.push_back(cyc + 1 + 2 * FRAME_CYC);
        idle_at = cyc + 1 + 2 * FRAME_CYC;
      end
      setov = valid && en && pend_v && !tk;
      if (valid && en) begin
        pend_c = cos; pend_s = sin; pend_v = 1'b1;
      end else if (tk) begin
        pend_v = 1'b0;
      end
      if (setov)    ovr_m = 1'b1;
      else if (clr) ovr_m = 1'b0;
    end
    cyc++;
  end

  // SPI decoder for the default instance: DAC samples MOSI on SCLK falling edges.
  logic        m_prev_cs, m_prev_sclk, m_chb;
  logic [23:0] m_bits, last_a, last_b;
  int          m_nbits, n_done = 0, n_csfall = 0;
  longint      m_a_fall = 0, m_last_done = 0, expv;

  initial forever begin
    @(negedge clk);
    if (!arst_n) begin
      m_prev_cs = 1'b1; m_prev_sclk = 1'b0; m_chb = 1'b0; m_bits = '0; m_nbits = 0;
    end else begin
      check("overrun", ovr, ovr_m);
      check("busy", busy, cyc < idle_at);
      if (m_prev_cs && !cs_n) begin
        expv = -1;
        if (exp_fall.size() > 0) expv = exp_fall.pop_front();
        check("cs_fall_cycle", cyc, expv);
        if (!m_chb) m_a_fall = cyc;
        m_bits = '0; m_nbits = 0; n_csfall++;
      end
      if (!cs_n && m_prev_sclk && !sclk) begin
        m_bits = {m_bits[22:0], mosi}; m_nbits++;
      end
      if (!m_prev_cs && cs_n) begin
        expv = -1;
        if (exp_frames.size() > 0) expv = exp_frames.pop_front();
        check("frame", m_bits, expv);
        check("frame_bits", m_nbits, 24);
        if (m_chb) last_b = m_bits; else last_a = m_bits;
        m_chb = !m_chb;
      end
      if (done) begin
        expv = -1;
        if (exp_done.size() > 0) expv = exp_done.pop_front();
        check("pair_done_cycle", cyc, expv);
        m_last_done = cyc; n_done++;
      end
      m_prev_cs = cs_n; m_prev_sclk = sclk;
    end
  end

  // Timing decoder for the CLK_DIV=1 / CS_GAP=1 instance.
  logic        f_prev_cs, f_prev_sclk, f_chb;
  logic [23:0] f_bits;
  int          f_nfall, f_ndone = 0;
  longint      f_fall_prev, f_last_rise, f_expv;

  initial forever begin
    @(negedge clk);
    if (!arst_n) begin
      f_prev_cs = 1'b1; f_prev_sclk = 1'b0; f_chb = 1'b0; f_fall_prev = -1; f_last_rise = -1;
      f_bits = '0; f_nfall = 0;
    end else begin
      if (f_prev_cs && !f_cs_n) begin
        if (f_chb) check("f_frame_period", cyc - f_fall_prev, 51);
        f_fall_prev = cyc; f_bits = '0; f_nfall = 0; f_last_rise = -1;
      end
      if (!f_cs_n && !f_prev_sclk && f_sclk) begin
        if (f_last_rise >= 0) check("f_sclk_period", cyc - f_last_rise, 2);
        f_last_rise = cyc;
      end
      if (!f_cs_n && f_prev_sclk && !f_sclk) begin
        f_bits = {f_bits[22:0], f_mosi}; f_nfall++;
      end
      if (!f_prev_cs && f_cs_n) begin
        check("f_falling_edges", f_nfall, 24);
        check("f_cs_low_cycles", cyc - f_fall_prev, 50);
        f_expv = -1;
        if (f_exp.size() > 0) f_expv = f_exp.pop_front();
        check("f_frame", f_bits, f_expv);
        f_chb = !f_chb;
      end
      if (f_done) f_ndone++;
      f_prev_cs = f_cs_n; f_prev_sclk = f_sclk;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] c, input logic [15:0] s);
    @(negedge clk); valid = 1'b1; cos = c; sin = s;
    @(negedge clk); valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, sclk, 0);
    check({tag, "_mosi"}, mosi, 0);
    check({tag, "_cs_n"}, cs_n, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_overrun"}, ovr, 0);
  endtask

  longint v_cyc;
  int     nd0, nf0, guard;
  logic [15:0] rc, rs;

  initial begin
    clk = 1'b0; arst_n = 1'b0; en = 1'b1; valid = 1'b0; clr = 1'b0;
    cos = '0; sin = '0; f_valid = 1'b0; f_cos = '0; f_sin = '0;
    idle(3);
    check_reset_outputs("rst");
    check("rst_f_cs_n", f_cs_n, 1);
    check("rst_f_sclk", f_sclk, 0);
    check("rst_f_mosi", f_mosi, 0);
    check("rst_f_busy", f_busy, 0);
    check("rst_f_done", f_done, 0);
    check("rst_f_overrun", f_ovr, 0);
    arst_n = 1'b1;
    idle(5);

    // Single directed pair.
    @(negedge clk); v_cyc = cyc; valid = 1'b1; cos = 16'h8001; sin = 16'h7FFE;
    @(negedge clk); valid = 1'b0;
    idle(220);
    check("pair_cs_latency", m_a_fall - v_cyc, 2);
    check("pair_done_latency", m_last_done - m_a_fall, 208);
    check("pair_frame_a", last_a, EXP_A);
    check("pair_frame_b", last_b, EXP_B);

    // Three pulses 10 cycles apart while busy: the middle pair is overwritten.
    nd0 = n_done;
    pulse(16'($urandom), 16'($urandom)); idle(8);
    pulse(16'($urandom), 16'($urandom)); idle(8);
    pulse(16'($urandom), 16'($urandom));
    check("overrun_set", ovr, 1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("overrun_cleared", ovr, 0);
    idle(450);
    check("overrun_pairs_sent", n_done - nd0, 2);

    // Capture in the same cycle the FSM takes the pending pair.
    nd0 = n_done;
    @(negedge clk); valid = 1'b1; cos = 16'($urandom); sin = 16'($urandom);
    @(negedge clk); cos = 16'($urandom); sin = 16'($urandom);
    @(negedge clk); valid = 1'b0;
    idle(440);
    check("simul_no_overrun", ovr, 0);
    check("simul_pairs_sent", n_done - nd0, 2);

    // Reset during SHIFT of frame A with a sample pending and overrun set.
    pulse(16'($urandom), 16'($urandom)); idle(8);
    pulse(16'($urandom), 16'($urandom)); idle(8);
    pulse(16'($urandom), 16'($urandom)); idle(8);
    check("pre_reset_overrun", ovr, 1);
    check("pre_reset_cs_low", cs_n, 0);
    @(posedge clk); #1 arst_n = 1'b0; #1;
    check_reset_outputs("midrst");
    idle(3); arst_n = 1'b1;
    nf0 = n_csfall;
    idle(300);
    check("no_frame_after_reset", n_csfall - nf0, 0);

    // Randomized traffic: gaps, enable drops, overrun clears.
    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 7) != 0);
      idle($urandom_range(1, 250));
      @(negedge clk); valid = 1'b1; cos = 16'($urandom); sin = 16'($urandom);
      clr = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk); cos = 16'($urandom); sin = 16'($urandom);
      end
      @(negedge clk); valid = 1'b0; clr = 1'b0;
    end
    en = 1'b1;
    guard = 0;
    while ((cyc < idle_at + 5 || pend_v) && guard < 2000) begin
      @(negedge clk); guard++;
    end
    check("drain_in_time", guard < 2000, 1);
    check("frames_left", exp_frames.size(), 0);
    check("done_left", exp_done.size(), 0);

    // Fast configuration: one pair.
    rc = 16'($urandom); rs = 16'($urandom);
    @(negedge clk); f_valid = 1'b1; f_cos = rc; f_sin = rs;
    f_exp.push_back({CMD_A, fmt(rc)});
    f_exp.push_back({CMD_B, fmt(rs)});
    @(negedge clk); f_valid = 1'b0;
    idle(120);
    check("f_pair_done_count", f_ndone, 1);
    check("f_frames_left", f_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dac_spi_writer.md
Name: dac_spi_writer

Overview:
- Downstream consumer of the sin/cos generator output stage.
- Captures each valid 16-bit cos/sin sample pair and serializes it as two 24-bit SPI frames to a dual-channel 16-bit DAC: cos to channel A, then sin to channel B with a simultaneous load.
- Single-entry pending buffer decouples the generator's sample rate from SPI frame time; overruns are flagged, never stalled.

Parameters:
- CLK_DIV, 2, i_clk cycles per SCLK half-period (>=1).
- CS_GAP, 4, i_clk cycles o_cs_n held high between frames (>=1).
- CMD_A, 8'h10, command byte for channel A (write buffer A, no load).
- CMD_B, 8'h24, command byte for channel B (write buffer B, load A+B).

Ports:
- i_clk  in  1  clock.
- inst_arst_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  capture enable; low finishes the current pair, then idles.
- i_valid  in  1  sample strobe from generator.
- i_cos  in  16  channel A sample.
- i_sin  in  16  channel B sample.
- i_clr_overrun  in  1  synchronous clear of o_overrun.
- o_sclk  out  1  SPI clock, idle low.
- o_mosi  out  1  SPI data, MSB first.
- o_cs_n  out  1  chip select, active low.
- o_busy  out  1  FSM not in IDLE.
- o_pair_done  out  1  one-cycle pulse when channel B frame plus gap completes.
- o_overrun  out  1  sticky: a pending sample was overwritten.

Behaviour:
- Reset values:
  - o_sclk=0, o_mosi=0, o_cs_n=1, o_busy=0, o_pair_done=0, o_overrun=0.
  - Pending buffer empty; FSM in IDLE.
- Reset mid-frame aborts immediately to these values. No partial-frame recovery; the DAC discards the frame on CS rise.
- Capture: when i_valid && i_enable, {i_cos,i_sin} is written to the pending register and pend_full is set on the next edge.
- Overrun: capture while pend_full=1 and the FSM is not taking the buffer in the same cycle overwrites the pending data and sets o_overrun.
- Simultaneous take+capture: the taken pair goes to the shifter, the new pair becomes pending, and no overrun is raised.
- i_clr_overrun clears o_overrun. If a clear and an overrun occur in the same cycle, the set wins.
- FSM states: IDLE, START, SHIFT, STOP, GAP.
  - IDLE: if pend_full, take the buffer (pend_full=0), load shreg={CMD_A,cos}, latch sin internally, channel=A, go to START. o_cs_n falls on entry to START, i.e. 2 cycles after the i_valid cycle when idle.
  - START: o_cs_n=0, o_sclk=0 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 48 half-periods of CLK_DIV cycles each.
    - On each SCLK rising edge, o_mosi takes the next shreg bit (bit 23 first).
    - The DAC samples on the falling edge.
    - After the 24th falling edge, go to STOP.
  - STOP: o_sclk=0 for CLK_DIV cycles, then o_cs_n=1, go to GAP.
  - GAP: o_cs_n=1 for CS_GAP cycles.
    - If channel=A: load {CMD_B,sin}, channel=B, go to START.
    - If channel=B: pulse o_pair_done, go to IDLE.
- Per-frame time: 50*CLK_DIV+CS_GAP cycles. Per pair: 2x that (208 at defaults).
- i_enable low mid-pair: the pair completes. New samples are not captured; an existing pending sample is still sent.
- Counters:
  - Half-period counter: ceil(log2(CLK_DIV+1)) bits.
  - Bit counter: 6 bits, counts 0..47.
  - Gap counter: sized to CS_GAP.
- o_mosi holds its last bit outside SHIFT and returns to 0 in IDLE.

Optional Feature:
- DAC_SPI_OFFSET_BINARY_EN: when defined, the MSB of each 16-bit data word is inverted at load time (two's complement to offset binary) for unipolar DACs. When undefined, data is sent unchanged. Command bytes are never altered.

Decomposition:
- Package dac_spi_pkg:
  - State encoding localparams (IDLE..GAP).
  - FRAME_W=24, DATA_W=16, CMD_W=8.
  - Default command constants.
- One natural sub-module: sclk_tick_gen. It is a CLK_DIV down-counter producing a half-period tick, enabled in START/SHIFT/STOP and reset on state entry.

Test Plan:
- Single pair (defaults), cos=16'h8001, sin=16'h7FFE:
  - MOSI frame A = 0x10,0x80,0x01; frame B = 0x24,0x7F,0xFE.
  - o_cs_n low 2 cycles after i_valid; o_pair_done exactly 208 cycles after CS first falls.
- Same stimulus with DAC_SPI_OFFSET_BINARY_EN: frame A data 0x0001, frame B data 0xFFFE, command bytes unchanged.
- Three i_valid pulses 10 cycles apart while busy:
  - First pair sent, third pair sent next; second pair dropped.
  - o_overrun=1 after the third pulse; i_clr_overrun returns it to 0.
- i_valid in the same cycle the FSM takes pending: no overrun, and both pairs are transmitted back-to-back.
- Deassert inst_arst_n during SHIFT of frame A: outputs immediately at reset values, pending empty. After release, no frame is emitted until a new i_valid.
- CLK_DIV=1, CS_GAP=1: SCLK period is 2 cycles, frame is 51 cycles, and 24 falling edges are counted per CS-low window.
